idli_sqi_ctrl: RTL

//  Sequences the SQI pins for a 23LC1024-style serial SRAM in quad mode.
//  - Accepts one read or write request, then issues command, address and turnaround nibbles.
//  - Streams data one nibble per cycle until the requester ends the burst on a 16-bit word boundary.
//  - Sits between the core's fetch/load-store sequencing and the top-level SQI pads.
//

---
 rtl/idli_pkg.sv | 31 +++
 rtl/idli_sqi_ctrl.sv | 120 ++++++++++++
 2 files changed

// File: rtl/idli_pkg.sv
// Shared types and constants for the idli core's SQI memory path.
// Pad direction, SQI sequencer states and serial SRAM command bytes.
package idli_pkg;

    typedef enum logic {
        SQI_MODE_IN,
        SQI_MODE_OUT
    } sqi_mode_t;

    typedef enum logic [2:0] {
        SQI_IDLE,
        SQI_CMD,
        SQI_ADDR,
        SQI_DUMMY,
        SQI_DATA
    } sqi_state_t;

    localparam logic [7:0] SQI_CMD_READ  = 8'h03;
    localparam logic [7:0] SQI_CMD_WRITE = 8'h02;

    // Command byte followed by the 24-bit byte address of a word.
    function automatic logic [31:0] sqi_frame(
        input logic        wr,
        input logic [15:0] addr
    );
        logic [7:0] cmd;
        cmd = wr ? SQI_CMD_WRITE : SQI_CMD_READ;
        return {cmd, 7'b0, addr, 1'b0};
    endfunction

endpackage

// File: rtl/idli_sqi_ctrl.sv
// SQI pin sequencer for a 23LC1024-style serial SRAM in quad mode.
// One request at a time: command, address, turnaround, then a nibble burst.
module idli_sqi_ctrl
    import idli_pkg::*;
#(
    parameter int DUMMY_CYCLES = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req,
    input  logic        i_wr,
    input  logic [15:0] i_addr,
    input  logic        i_end,
    output logic        o_ack,
    input  logic [3:0]  i_wdata,
    output logic        o_wdata_rd,
    output logic [3:0]  o_rdata,
    output logic        o_rdata_vld,
    output logic        o_sqi_cs,
    output sqi_mode_t   o_sqi_mode,
    output logic [3:0]  o_sqi_sio,
    input  logic [3:0]  i_sqi_sio
);

    localparam logic [2:0] DUMMY_LAST = 3'(DUMMY_CYCLES - 1);

    sqi_state_t  state;
    sqi_state_t  state_n;
    logic [2:0]  phase;
    logic [1:0]  nib;
    logic        end_pend;
    logic        wr_q;
    logic [31:0] sr;

    logic        in_idle;
    logic        in_data;
    logic        rd_sample;

    assign in_idle   = (state == SQI_IDLE);
    assign in_data   = (state == SQI_DATA);
    assign rd_sample = in_data && !wr_q;

    always_comb begin
        state_n = state;
        unique case (state)
            SQI_IDLE: begin
                if (i_req) state_n = SQI_CMD;
            end
            SQI_CMD: begin
                if (phase == 3'd1) state_n = SQI_ADDR;
            end
            SQI_ADDR: begin
                if (phase == 3'd5) state_n = wr_q ? SQI_DATA : SQI_DUMMY;
            end
            SQI_DUMMY: begin
                if (phase == DUMMY_LAST) state_n = SQI_DATA;
            end
            SQI_DATA: begin
                if (nib == 2'd3 && (end_pend || i_end)) state_n = SQI_IDLE;
            end
            default: state_n = SQI_IDLE;
        endcase
    end

    // Pin and handshake outputs decode directly from the registered state.
    always_comb begin
        o_ack      = in_idle && i_req;
        o_sqi_cs   = in_idle;
        o_wdata_rd = in_data && wr_q;
        o_sqi_mode = SQI_MODE_IN;
        o_sqi_sio  = 4'h0;
        unique case (state)
            SQI_CMD, SQI_ADDR: begin
                o_sqi_mode = SQI_MODE_OUT;
                o_sqi_sio  = sr[31:28];
            end
            SQI_DATA: begin
                if (wr_q) begin
                    o_sqi_mode = SQI_MODE_OUT;
                    o_sqi_sio  = i_wdata;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= SQI_IDLE;
            phase       <= 3'd0;
            nib         <= 2'd0;
            end_pend    <= 1'b0;
            wr_q        <= 1'b0;
            sr          <= 32'h0;
            o_rdata     <= 4'h0;
            o_rdata_vld <= 1'b0;
        end else begin
            state <= state_n;

            if (in_idle || state_n != state) phase <= 3'd0;
            else                             phase <= phase + 3'd1;

            nib <= in_data ? nib + 2'd1 : 2'd0;

            if (state_n == SQI_IDLE)      end_pend <= 1'b0;
            else if (!in_idle && i_end)   end_pend <= 1'b1;

            if (in_idle && i_req) begin
                wr_q <= i_wr;
                sr   <= sqi_frame(i_wr, i_addr);
            end else if (state == SQI_CMD || state == SQI_ADDR) begin
                sr <= {sr[27:0], 4'h0};
            end

            o_rdata_vld <= rd_sample;
            if (rd_sample) o_rdata <= i_sqi_sio;
        end
    end

endmodule
